lsu_unit: RTL and testbench

//  Load/store unit answering EXE_stage's LSU issue port. Computes rs1+imm, buffers stores until ROB commit, and runs loads.

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/lsu_store_buffer.sv | 86 ++++++++
 rtl/lsu_unit.sv | 149 ++++++++++++++
 tb/tb_lsu_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: store-buffer entry, load FSM states,
// funct3 encodings and the byte-lane align/extend functions.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {LIdle, LIssue, LResp, LDone} ld_state_e;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_entry_t;

    // Byte-lane offset actually used by the access size (H uses addr[1], W none).
    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_off = off;
            2'b01:   lane_off = {off[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] st_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   st_mask = 4'b0001 << lane_off(f3, off);
            2'b01:   st_mask = 4'b0011 << lane_off(f3, off);
            default: st_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [31:0] v;
        case (f3[1:0])
            2'b00:   v = {24'h0, d[7:0]};
            2'b01:   v = {16'h0, d[15:0]};
            default: v = d;
        endcase
        st_data = v << {lane_off(f3, off), 3'b000};
    endfunction

    function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
        logic [31:0] s;
        s = rdata >> {lane_off(f3, off), 3'b000};
        case (f3)
            F3_B:    ld_extend = {{24{s[7]}}, s[7:0]};
            F3_BU:   ld_extend = {24'h0, s[7:0]};
            F3_H:    ld_extend = {{16{s[15]}}, s[15:0]};
            F3_HU:   ld_extend = {16'h0, s[15:0]};
            default: ld_extend = s;
        endcase
    endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// In-order store buffer: append at tail, in-order commit, drain of committed head,
// rollback to the committed prefix on flush, and age-qualified address conflict query.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ROB_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  sb_entry_t        i_push_entry,
    input  logic [ROB_W-1:0] i_push_rob,
    input  logic             i_commit,
    input  logic             i_flush,
    input  logic             i_pop,
    input  logic [29:0]      i_q_waddr,
    input  logic [ROB_W-1:0] i_q_rob,
    input  logic [ROB_W-1:0] i_rob_head,
    output logic             o_full,
    output logic             o_head_committed,
    output sb_entry_t        o_head,
    output logic             o_conflict
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        r_entry [DEPTH];
    logic [ROB_W-1:0] r_rob   [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail, w_head_nxt;
    logic [CNT_W-1:0] r_count, r_ncommit, w_ncommit_nxt;
    logic             w_commit, w_pop, w_push;
    logic [ROB_W-1:0] w_age_q;
    logic [DEPTH-1:0] w_hit;

    // Committed entries always form a prefix starting at the head.
    assign o_full           = (r_count == CNT_W'(DEPTH));
    assign o_head_committed = (r_ncommit != '0);
    assign o_head           = r_entry[r_head];
    assign w_commit         = i_commit && (r_ncommit != r_count);
    assign w_pop            = i_pop && o_head_committed;
    assign w_push           = i_push && !i_flush && !o_full;
    assign w_head_nxt       = r_head + PTR_W'(w_pop);
    assign w_ncommit_nxt    = r_ncommit + CNT_W'(w_commit) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ncommit <= '0;
        end else begin
            r_head    <= w_head_nxt;
            r_ncommit <= w_ncommit_nxt;
            if (i_flush) begin
                r_count <= w_ncommit_nxt;
                r_tail  <= w_head_nxt + w_ncommit_nxt[PTR_W-1:0];
            end else begin
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                r_tail  <= r_tail + PTR_W'(w_push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entry[r_tail] <= i_push_entry;
            r_rob[r_tail]   <= i_push_rob;
        end
    end

    assign w_age_q = i_q_rob - i_rob_head;

    // Committed entries have already left the ROB, so they are older than any in-flight load.
    for (genvar g = 0; g < DEPTH; g++) begin : g_query
        logic [PTR_W-1:0] w_pos;
        logic [ROB_W-1:0] w_age_e;
        assign w_pos    = PTR_W'(g) - r_head;
        assign w_age_e  = r_rob[g] - i_rob_head;
        assign w_hit[g] = ({1'b0, w_pos} < r_count) && (r_entry[g].waddr == i_q_waddr) &&
                          (({1'b0, w_pos} < r_ncommit) || (w_age_e < w_age_q));
    end

    assign o_conflict = |w_hit;

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: address generation, store buffering until commit, and a four-state load
// FSM sharing the single data-memory port with the store-buffer drain.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned ROB_W    = 3,
    parameter int unsigned PRD_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i_valid,
    input  logic             st_i_valid,
    input  logic [ROB_W-1:0] lsu_i_rob_idx,
    input  logic [PRD_W-1:0] lsu_i_rd,
    input  logic [2:0]       lsu_i_f3,
    input  logic [31:0]      lsu_i_rs1_data,
    input  logic [31:0]      lsu_i_rs2_data,
    input  logic [31:0]      lsu_i_imm,
    output logic             ld_i_ready,
    output logic             st_i_ready,
    output logic             ld_o_valid,
    output logic [ROB_W-1:0] ld_o_rob_idx,
    output logic [PRD_W-1:0] ld_o_rd,
    output logic [31:0]      ld_o_data,
    output logic             st_o_valid,
    output logic [ROB_W-1:0] st_o_rob_idx,
    input  logic [ROB_W-1:0] rob_head_idx,
    input  logic             commit_st,
    input  logic             flush,
    output logic             dm_en,
    output logic [3:0]       dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata
);
    ld_state_e        r_state, w_state_nxt;
    logic [31:0]      r_ld_addr, r_ld_data;
    logic [2:0]       r_ld_f3;
    logic [ROB_W-1:0] r_ld_rob, r_st_rob;
    logic [PRD_W-1:0] r_ld_rd;
    logic             r_st_valid;

    logic [31:0] w_addr;
    sb_entry_t   w_st_entry, w_sb_head;
    logic        w_st_acc, w_ld_acc, w_sb_full, w_sb_head_committed, w_conflict;
    logic        w_ld_req, w_ld_grant, w_drain;

    assign w_addr     = lsu_i_rs1_data + lsu_i_imm;
    assign w_st_acc   = st_i_valid && st_i_ready && !flush;
    assign w_ld_acc   = ld_i_valid && ld_i_ready && !flush;
    assign w_st_entry = '{waddr: w_addr[31:2],
                          data:  st_data(lsu_i_f3, w_addr[1:0], lsu_i_rs2_data),
                          mask:  st_mask(lsu_i_f3, w_addr[1:0])};

    lsu_store_buffer #(
        .DEPTH (SB_DEPTH),
        .ROB_W (ROB_W)
    ) u_sb (
        .clk              (clk),
        .rst              (rst),
        .i_push           (w_st_acc),
        .i_push_entry     (w_st_entry),
        .i_push_rob       (lsu_i_rob_idx),
        .i_commit         (commit_st),
        .i_flush          (flush),
        .i_pop            (w_drain),
        .i_q_waddr        (r_ld_addr[31:2]),
        .i_q_rob          (r_ld_rob),
        .i_rob_head       (rob_head_idx),
        .o_full           (w_sb_full),
        .o_head_committed (w_sb_head_committed),
        .o_head           (w_sb_head),
        .o_conflict       (w_conflict)
    );

    assign st_i_ready = !w_sb_full;

    // Drain takes the port unless an unblocked load is waiting and the buffer has room.
    assign w_ld_req   = (r_state == LIssue) && !w_conflict;
    assign w_drain    = w_sb_head_committed && (w_sb_full || !w_ld_req);
    assign w_ld_grant = w_ld_req && !w_drain && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LIdle:   if (w_ld_acc) w_state_nxt = LIssue;
            LIssue:  if (w_ld_grant) w_state_nxt = LResp;
            LResp:   w_state_nxt = LDone;
            LDone:   w_state_nxt = LIdle;
            default: w_state_nxt = LIdle;
        endcase
        if (flush) w_state_nxt = LIdle;
    end

    always_comb begin
        ld_i_ready = (r_state == LIdle);
        ld_o_valid = (r_state == LDone) && !flush;
        dm_en      = w_drain || w_ld_grant;
        dm_we      = w_drain ? w_sb_head.mask : 4'b0000;
        dm_wdata   = w_drain ? w_sb_head.data : 32'h0;
        if (w_drain) begin
            dm_addr = {w_sb_head.waddr, 2'b00};
        end else if (w_ld_grant) begin
            dm_addr = {r_ld_addr[31:2], 2'b00};
        end else begin
            dm_addr = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_addr  <= '0;
            r_ld_f3    <= '0;
            r_ld_rob   <= '0;
            r_ld_rd    <= '0;
            r_ld_data  <= '0;
            r_st_valid <= 1'b0;
            r_st_rob   <= '0;
        end else begin
            r_st_valid <= w_st_acc;
            if (w_st_acc) r_st_rob <= lsu_i_rob_idx;
            if (w_ld_acc) begin
                r_ld_addr <= w_addr;
                r_ld_f3   <= lsu_i_f3;
                r_ld_rob  <= lsu_i_rob_idx;
                r_ld_rd   <= lsu_i_rd;
            end
            if ((r_state == LResp) && !flush) begin
                r_ld_data <= ld_extend(r_ld_f3, r_ld_addr[1:0], dm_rdata);
            end
        end
    end

    assign ld_o_rob_idx = r_ld_rob;
    assign ld_o_rd      = r_ld_rd;
    assign ld_o_data    = r_ld_data;
    assign st_o_valid   = r_st_valid;
    assign st_o_rob_idx = r_st_rob;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit with a 1-cycle-latency word memory model and event monitors.
module tb_lsu_unit;
    import lsu_pkg::*;

    localparam int unsigned ROB_W = 3;
    localparam int unsigned PRD_W = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_i_valid, st_i_valid, commit_st, flush;
    logic [ROB_W-1:0] lsu_i_rob_idx, rob_head_idx;
    logic [PRD_W-1:0] lsu_i_rd;
    logic [2:0]       lsu_i_f3;
    logic [31:0]      lsu_i_rs1_data, lsu_i_rs2_data, lsu_i_imm;
    logic             ld_i_ready, st_i_ready, ld_o_valid, st_o_valid;
    logic [ROB_W-1:0] ld_o_rob_idx, st_o_rob_idx;
    logic [PRD_W-1:0] ld_o_rd;
    logic [31:0]      ld_o_data;
    logic             dm_en;
    logic [3:0]       dm_we;
    logic [31:0]      dm_addr, dm_wdata;
    logic [31:0]      dm_rdata = 32'h0;

    lsu_unit #(
        .SB_DEPTH (4),
        .ROB_W    (ROB_W),
        .PRD_W    (PRD_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_i_valid     (ld_i_valid),
        .st_i_valid     (st_i_valid),
        .lsu_i_rob_idx  (lsu_i_rob_idx),
        .lsu_i_rd       (lsu_i_rd),
        .lsu_i_f3       (lsu_i_f3),
        .lsu_i_rs1_data (lsu_i_rs1_data),
        .lsu_i_rs2_data (lsu_i_rs2_data),
        .lsu_i_imm      (lsu_i_imm),
        .ld_i_ready     (ld_i_ready),
        .st_i_ready     (st_i_ready),
        .ld_o_valid     (ld_o_valid),
        .ld_o_rob_idx   (ld_o_rob_idx),
        .ld_o_rd        (ld_o_rd),
        .ld_o_data      (ld_o_data),
        .st_o_valid     (st_o_valid),
        .st_o_rob_idx   (st_o_rob_idx),
        .rob_head_idx   (rob_head_idx),
        .commit_st      (commit_st),
        .flush          (flush),
        .dm_en          (dm_en),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata)
    );

    always #5 clk = ~clk;

    // Memory model, cycle counter and write monitor; preloads go through poke_* below.
    logic [31:0] mem [1024];
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [3:0]  last_we;
    logic [31:0] last_wdata, last_waddr;
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr, poke_data;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (poke_en) mem[poke_addr[11:2]] = poke_data;
        if (dm_en) begin
            if (dm_we == 4'b0000) begin
                dm_rdata <= mem[dm_addr[11:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (dm_we[b]) mem[dm_addr[11:2]][8*b +: 8] = dm_wdata[8*b +: 8];
                wr_cnt     = wr_cnt + 1;
                last_we    = dm_we;
                last_wdata = dm_wdata;
                last_waddr = dm_addr;
            end
        end
    end

    int               ld_cnt = 0, st_cnt = 0, ld_cyc = 0, st_cyc = 0;
    logic [31:0]      ld_data;
    logic [PRD_W-1:0] ld_rd;
    logic [ROB_W-1:0] ld_rob, st_rob;

    always @(negedge clk) begin
        if (ld_o_valid) begin
            ld_cnt  = ld_cnt + 1;
            ld_cyc  = cyc;
            ld_data = ld_o_data;
            ld_rd   = ld_o_rd;
            ld_rob  = ld_o_rob_idx;
        end
        if (st_o_valid) begin
            st_cnt = st_cnt + 1;
            st_cyc = cyc;
            st_rob = st_o_rob_idx;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic set_op(input logic [ROB_W-1:0] rob, input logic [PRD_W-1:0] rd,
                          input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] data);
        lsu_i_rob_idx = rob; lsu_i_rd = rd; lsu_i_f3 = f3;
        lsu_i_rs1_data = rs1; lsu_i_imm = imm; lsu_i_rs2_data = data;
    endtask

    task automatic do_store(input logic [ROB_W-1:0] rob, input logic [2:0] f3,
                            input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] d);
        set_op(rob, '0, f3, rs1, imm, d);
        st_i_valid = 1'b1;
        tick();
        st_i_valid = 1'b0;
    endtask

    task automatic do_load(input logic [ROB_W-1:0] rob, input logic [PRD_W-1:0] rd,
                           input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm);
        set_op(rob, rd, f3, rs1, imm, 32'h0);
        ld_i_valid = 1'b1;
        tick();
        ld_i_valid = 1'b0;
    endtask

    task automatic wait_ld(input int n0, input int budget);
        for (int i = 0; i < budget && ld_cnt == n0; i++) tick();
    endtask

    task automatic commit1();
        commit_st = 1'b1;
        tick();
        commit_st = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (ld_i_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b exp 1", ld_i_ready); end
        checks++; if (st_i_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_i_ready); end
        checks++; if (ld_o_valid !== 1'b0 || st_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valids got %b%b exp 00", ld_o_valid, st_o_valid); end
        checks++; if (dm_en !== 1'b0 || dm_we !== 4'h0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin errors++; $display("FAIL reset_dm got en=%b we=%h addr=%h exp 0", dm_en, dm_we, dm_addr); end
        checks++; if (ld_o_data !== 32'h0 || ld_o_rd !== '0 || ld_o_rob_idx !== '0) begin errors++; $display("FAIL reset_ld_out got %h exp 0", ld_o_data); end
    endtask

    task automatic test_lw();
        int n0, t0;
        poke(32'h104, 32'hDEADBEEF);
        n0 = ld_cnt; t0 = cyc;
        do_load(3'd2, 7'd5, F3_W, 32'h100, 32'h4);
        checks++; if (ld_i_ready !== 1'b0) begin errors++; $display("FAIL lw_busy got %b exp 0", ld_i_ready); end
        wait_ld(n0, 10);
        checks++; if (ld_cnt !== n0 + 1) begin errors++; $display("FAIL lw_count got %0d exp %0d", ld_cnt, n0 + 1); end
        checks++; if (ld_cyc - t0 !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", ld_cyc - t0); end
        checks++; if (ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", ld_data); end
        checks++; if (ld_rd !== 7'd5 || ld_rob !== 3'd2) begin errors++; $display("FAIL lw_tags got rd=%0d rob=%0d exp 5 2", ld_rd, ld_rob); end
    endtask

    task automatic test_subword();
        logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] imms [4] = '{32'd3, 32'd3, 32'd2, 32'd2};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        int n0, t0, w0;
        poke(32'h100, 32'h80FF0000);
        for (int i = 0; i < 4; i++) begin
            n0 = ld_cnt;
            do_load(3'd1, 7'd6, f3s[i], 32'h100, imms[i]);
            wait_ld(n0, 10);
            checks++; if (ld_cnt !== n0 + 1 || ld_data !== exps[i]) begin errors++; $display("FAIL subword_load_%0d got %h exp %h", i, ld_data, exps[i]); end
        end
        t0 = cyc; n0 = st_cnt; w0 = wr_cnt;
        do_store(3'd1, F3_H, 32'h100, 32'h2, 32'h00001234);
        tick();
        checks++; if (st_cnt !== n0 + 1 || st_cyc - t0 !== 1 || st_rob !== 3'd1) begin errors++; $display("FAIL sh_st_o got cnt=%0d dt=%0d rob=%0d exp %0d 1 1", st_cnt, st_cyc - t0, st_rob, n0 + 1); end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL sh_no_early_write got %0d exp %0d", wr_cnt, w0); end
        commit1(); tick(); tick();
        checks++; if (wr_cnt !== w0 + 1 || last_we !== 4'b1100 || last_wdata !== 32'h12340000 || last_waddr !== 32'h100) begin errors++; $display("FAIL sh_drain got we=%b wd=%h a=%h exp 1100 12340000 100", last_we, last_wdata, last_waddr); end
        do_store(3'd2, F3_B, 32'h100, 32'h1, 32'h000000AB);
        commit1(); tick(); tick();
        checks++; if (wr_cnt !== w0 + 2 || last_we !== 4'b0010 || last_wdata !== 32'h0000AB00) begin errors++; $display("FAIL sb_drain got we=%b wd=%h exp 0010 0000ab00", last_we, last_wdata); end
        n0 = ld_cnt;
        do_load(3'd3, 7'd7, F3_W, 32'h100, 32'h0);
        wait_ld(n0, 10);
        checks++; if (ld_data !== 32'h1234AB00) begin errors++; $display("FAIL merged_word got %h exp 1234ab00", ld_data); end
    endtask

    task automatic test_raw_wait();
        int n0, w0;
        poke(32'h200, 32'h11111111);
        w0 = wr_cnt;
        do_store(3'd1, F3_W, 32'h200, 32'h0, 32'h000000A5);
        n0 = ld_cnt;
        do_load(3'd3, 7'd9, F3_W, 32'h200, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        checks++; if (ld_cnt !== n0 || ld_i_ready !== 1'b0) begin errors++; $display("FAIL raw_blocked got cnt=%0d rdy=%b exp %0d 0", ld_cnt, ld_i_ready, n0); end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL raw_no_drain got %0d exp %0d", wr_cnt, w0); end
        commit1();
        wait_ld(n0, 20);
        checks++; if (ld_cnt !== n0 + 1 || ld_data !== 32'hA5 || ld_rd !== 7'd9) begin errors++; $display("FAIL raw_data got %h rd=%0d exp a5 9", ld_data, ld_rd); end
    endtask

    task automatic test_younger_store();
        int n0, t0, w0;
        do_store(3'd4, F3_W, 32'h200, 32'h0, 32'h00000077);
        n0 = ld_cnt; t0 = cyc;
        do_load(3'd1, 7'd10, F3_W, 32'h200, 32'h0);
        wait_ld(n0, 10);
        checks++; if (ld_cyc - t0 !== 3 || ld_data !== 32'hA5) begin errors++; $display("FAIL younger_no_wait got dt=%0d d=%h exp 3 a5", ld_cyc - t0, ld_data); end
        w0 = wr_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (wr_cnt !== w0 || mem[32'h200 >> 2] !== 32'hA5) begin errors++; $display("FAIL younger_squashed got wr=%0d m=%h exp %0d a5", wr_cnt, mem[32'h200 >> 2], w0); end
    endtask

    task automatic test_full();
        int w0;
        poke(32'h308, 32'hCAFE0000);
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) do_store(3'(i + 1), F3_W, 32'h300, 32'(4 * i), 32'h100 + 32'(i));
        checks++; if (st_i_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", st_i_ready); end
        commit_st = 1'b1;
        tick();
        checks++; if (st_i_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle got %b exp 0", st_i_ready); end
        tick();
        commit_st = 1'b0;
        checks++; if (st_i_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", st_i_ready); end
        tick(); tick(); tick();
        checks++; if (wr_cnt !== w0 + 2 || mem[32'h300 >> 2] !== 32'h100 || mem[32'h304 >> 2] !== 32'h101) begin errors++; $display("FAIL full_two_drains got wr=%0d exp %0d", wr_cnt, w0 + 2); end
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (wr_cnt !== w0 + 2 || mem[32'h308 >> 2] !== 32'hCAFE0000) begin errors++; $display("FAIL full_rollback got wr=%0d m=%h exp %0d cafe0000", wr_cnt, mem[32'h308 >> 2], w0 + 2); end
    endtask

    task automatic test_flush_inflight();
        int n0, w0, t0;
        for (int i = 0; i < 4; i++) poke(32'h500 + 32'(4 * i), 32'hEEEE0000 + 32'(i));
        poke(32'h600, 32'h600D0000);
        w0 = wr_cnt; n0 = ld_cnt;
        for (int i = 0; i < 4; i++) do_store(3'(i + 1), F3_W, 32'h500, 32'(4 * i), 32'h500 + 32'(i));
        set_op(3'd5, 7'd11, F3_W, 32'h600, 32'h0, 32'h0);
        ld_i_valid = 1'b1; commit_st = 1'b1;
        tick();
        ld_i_valid = 1'b0;
        tick();
        commit_st = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (ld_i_ready !== 1'b1) begin errors++; $display("FAIL flush_ld_ready got %b exp 1", ld_i_ready); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (ld_cnt !== n0) begin errors++; $display("FAIL flush_no_ld_valid got %0d exp %0d", ld_cnt, n0); end
        checks++; if (wr_cnt !== w0 + 2 || mem[32'h500 >> 2] !== 32'h500 || mem[32'h504 >> 2] !== 32'h501) begin errors++; $display("FAIL flush_committed_drain got wr=%0d exp %0d", wr_cnt, w0 + 2); end
        checks++; if (mem[32'h508 >> 2] !== 32'hEEEE0002 || mem[32'h50C >> 2] !== 32'hEEEE0003) begin errors++; $display("FAIL flush_uncommitted got %h %h exp eeee0002 eeee0003", mem[32'h508 >> 2], mem[32'h50C >> 2]); end
        checks++; if (st_i_ready !== 1'b1) begin errors++; $display("FAIL flush_st_ready got %b exp 1", st_i_ready); end
        n0 = ld_cnt; t0 = cyc;
        do_load(3'd7, 7'd12, F3_W, 32'h508, 32'h0);
        wait_ld(n0, 10);
        checks++; if (ld_cyc - t0 !== 3 || ld_data !== 32'hEEEE0002) begin errors++; $display("FAIL flush_sb_empty got dt=%0d d=%h exp 3 eeee0002", ld_cyc - t0, ld_data); end
    endtask

    task automatic test_flush_commit();
        int n0, w0, s0;
        poke(32'h700, 32'h0);
        poke(32'h704, 32'h0BAD0000);
        poke(32'h708, 32'h0BAD0001);
        w0 = wr_cnt; n0 = ld_cnt;
        do_store(3'd1, F3_W, 32'h700, 32'h0, 32'h701);
        do_store(3'd2, F3_W, 32'h704, 32'h0, 32'h702);
        set_op(3'd3, 7'd13, F3_W, 32'h708, 32'h0, 32'h703);
        st_i_valid = 1'b1; ld_i_valid = 1'b1; commit_st = 1'b1; flush = 1'b1;
        tick();
        st_i_valid = 1'b0; ld_i_valid = 1'b0; commit_st = 1'b0; flush = 1'b0;
        s0 = st_cnt;
        checks++; if (ld_i_ready !== 1'b1) begin errors++; $display("FAIL fc_load_dropped got %b exp 1", ld_i_ready); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (st_cnt !== s0) begin errors++; $display("FAIL fc_store_dropped got %0d exp %0d", st_cnt, s0); end
        checks++; if (wr_cnt !== w0 + 1 || mem[32'h700 >> 2] !== 32'h701) begin errors++; $display("FAIL fc_commit_survives got wr=%0d m=%h exp %0d 701", wr_cnt, mem[32'h700 >> 2], w0 + 1); end
        checks++; if (mem[32'h704 >> 2] !== 32'h0BAD0000 || mem[32'h708 >> 2] !== 32'h0BAD0001 || ld_cnt !== n0) begin errors++; $display("FAIL fc_squashed got %h %h ld=%0d", mem[32'h704 >> 2], mem[32'h708 >> 2], ld_cnt); end
    endtask

    initial begin
        rst = 1'b1; ld_i_valid = 1'b0; st_i_valid = 1'b0; commit_st = 1'b0; flush = 1'b0;
        rob_head_idx = '0;
        set_op('0, '0, 3'b000, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_lw();
        test_subword();
        test_raw_wait();
        test_younger_store();
        test_full();
        test_flush_inflight();
        test_flush_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
